// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller: FSM state codes,
// divider iteration count, divide-by-zero LO value and sign helpers.
package muldiv_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL1 = 3'd1;
  localparam logic [2:0] ST_MUL2 = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;

  // Magnitude of a value that is two's complement when sgn is set
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's complement negation
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
// start loads the operands; done pulses during the 32nd iteration so the
// final quotient/remainder are on the outputs in the following cycle.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q;
  logic [5:0]  cnt_q, cnt_d;
  logic        act_q, act_d;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    done   = act_q && (cnt_q == 6'(DIV_ITERS - 1));
    if (start) begin
      quo_d = dividend;
      rem_d = 32'd0;
      cnt_d = 6'd0;
      act_d = 1'b1;
    end else if (act_q) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (done) act_d = 1'b0;
    end
  end

  // Iteration state; reset abandons any division in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      cnt_q <= 6'd0;
      act_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  // Divisor held for the whole division
  always_ff @(posedge clk) begin
    if (start) dvs_q <= divisor;
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller and owner of the HI/LO registers.
// Sequences a 2-cycle multiply and a 32-iteration divide and stalls any
// HI/LO-dependent instruction while an operation is in flight.
// Optional: MULDIV_DIV0_FAST_EN sends divide-by-zero straight to DONE.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  mult_signal,
  input  logic [1:0]  div_signal,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [2:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q;       // multiplicand, or raw dividend for div-by-zero HI
  logic [31:0] b_q;       // multiplier
  logic        msgn_q;    // signed multiply
  logic        qneg_q;    // negate quotient
  logic        rneg_q;    // negate remainder
  logic        div0_q;    // divisor was zero
  logic [63:0] prod_q;

  logic        is_mult, is_div, is_dep, accept, div_start, rt_zero;
  logic [63:0] ma, mb, pw;
  logic        div_done;
  logic [31:0] div_quo, div_rem;
  logic [31:0] q_fix, r_fix;

  assign is_mult = req_valid & mult_signal[1];
  assign is_div  = req_valid & div_signal[1];
  assign is_dep  = mult_signal[1] | div_signal[1] | mthi | mtlo | rd_hi | rd_lo;
  assign busy    = (state_q != ST_IDLE);
  assign stall   = busy & req_valid & is_dep;
  assign accept  = (state_q == ST_IDLE) & req_valid & ~stall;
  assign rt_zero = (rt_data == 32'd0);

`ifdef MULDIV_DIV0_FAST_EN
  assign div_start = accept & is_div & ~is_mult & ~rt_zero;
`else
  assign div_start = accept & is_div & ~is_mult;
`endif

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (abs32(rs_data, div_signal[0])),
    .divisor   (abs32(rt_data, div_signal[0])),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // 64-bit product; operand extension selects signed vs unsigned
  always_comb begin
    ma = msgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    mb = msgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    pw = ma * mb;
  end

  assign q_fix = neg_if(div_quo, qneg_q);
  assign r_fix = neg_if(div_rem, rneg_q);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mult) begin
          state_d = ST_MUL1;
        end else if (accept && is_div) begin
`ifdef MULDIV_DIV0_FAST_EN
          state_d = rt_zero ? ST_DONE : ST_DIV;
`else
          state_d = ST_DIV;
`endif
        end
      end
      ST_MUL1: state_d = ST_MUL2;
      ST_MUL2: state_d = ST_IDLE;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // HI/LO writeback: product, corrected quotient/remainder, or mthi/mtlo
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      ST_MUL2: begin
        hi_d = prod_q[63:32];
        lo_d = prod_q[31:0];
      end
      ST_DONE: begin
        if (div0_q) begin
          hi_d = a_q;
          lo_d = DIV0_LO;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      ST_IDLE: begin
        if (accept && !is_mult && !is_div) begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      default: ;
    endcase
  end

  // Control state and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand and sign capture at accept, product capture in MUL1
  always_ff @(posedge clk) begin
    if (accept && is_mult) begin
      a_q    <= rs_data;
      b_q    <= rt_data;
      msgn_q <= mult_signal[0];
    end else if (accept && is_div) begin
      a_q    <= rs_data;
      qneg_q <= div_signal[0] & (rs_data[31] ^ rt_data[31]);
      rneg_q <= div_signal[0] & rs_data[31];
      div0_q <= rt_zero;
    end
    if (state_q == ST_MUL1) prod_q <= pw;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
